// File: rtl/handshake_domain_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : domain_cross_pkg
//  Description : Shared types and constants for the toggle-based req/ack
//                domain-crossing blocks (receiver and matching transmitter).
//  Contents    : state_e          - receiver FSM state encoding
//                SYNC_STAGES_MIN  - smallest legal synchronizer depth
//  Revision    : 1.0 - initial release
// ============================================================================
package domain_cross_pkg;

    // Two flops is the minimum that gives the first stage a full cycle to
    // resolve metastability before the value is used.
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

endpackage : domain_cross_pkg
`default_nettype wire

// File: rtl/handshake_domain_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_domain_rx_if
//  Description : Bundle of the cross-domain request/acknowledge signals and
//                the destination-side valid/ready output stream.
//  Signals     : req_a     - request toggle from the clk_a domain
//                data_a    - sender data, stable while req_a != ack_b
//                ack_b     - acknowledge toggle from the clk_b domain
//                out_valid - out_data holds a captured word
//                out_data  - captured word
//                out_ready - consumer accepts out_data this cycle
//                overrun   - sticky protocol-violation flag
//  Modports    : master - environment (sender + consumer)
//                slave  - the receiver block
//  Revision    : 1.0 - initial release
// ============================================================================
interface handshake_domain_rx_if #(
    parameter int WIDTH = 32
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             ack_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             overrun;

    modport master (
        output req_a,
        output data_a,
        output out_ready,
        input  ack_b,
        input  out_valid,
        input  out_data,
        input  overrun
    );

    modport slave (
        input  req_a,
        input  data_a,
        input  out_ready,
        output ack_b,
        output out_valid,
        output out_data,
        output overrun
    );

endinterface : handshake_domain_rx_if
`default_nettype wire

// File: rtl/handshake_domain_rx_toggle_sync.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_sync
//  Description : Parameterized-depth single-bit synchronizer with
//                asynchronous active-high reset. Carries a toggle signal
//                into the domain of clk; the output is the last stage.
//  Ports       : clk - destination clock
//                rst - asynchronous reset, active-high (chain clears to 0)
//                d_i - asynchronous input bit
//                q_o - synchronized bit
//  Parameters  : STAGES - flops in the chain, >= SYNC_STAGES_MIN
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_sync
    import domain_cross_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    generate
        if (STAGES < SYNC_STAGES_MIN) begin : g_stages_check
            $error("toggle_sync: STAGES must be >= %0d", SYNC_STAGES_MIN);
        end
    endgenerate

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : toggle_sync
`default_nettype wire

// File: rtl/handshake_domain_rx.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_domain_rx
//  Description : Receiving end of a toggle-based req/ack multi-bit domain
//                crossing, clocked in the destination domain (clk_b).
//                The sender places data_a and toggles req_a. Once the
//                synchronized request differs from ack_b, data_a is captured
//                and presented on a valid/ready stream. ack_b toggles on the
//                edge that completes the out_valid && out_ready handshake.
//  Ports       : clk_b - destination-domain clock
//                rst   - asynchronous reset, active-high
//                bus   - handshake_domain_rx_if.slave
//                        (req_a, data_a, out_ready in;
//                         ack_b, out_valid, out_data, overrun out)
//  Parameters  : WIDTH       - data word width in bits
//                SYNC_STAGES - depth of the req_a synchronizer (>= 2)
//  Options     : DOMAIN_CROSS_OVERRUN_DET_EN - when defined, builds the
//                sticky overrun detector; otherwise overrun is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_domain_rx
    import domain_cross_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk_b,
    input  wire logic              rst,
    handshake_domain_rx_if.slave   bus
);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_sync_stages_check
            $error("handshake_domain_rx: SYNC_STAGES must be >= %0d",
                   SYNC_STAGES_MIN);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Request synchronizer
    // ------------------------------------------------------------------------
    logic req_sync;

    toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk_b),
        .rst (rst),
        .d_i (bus.req_a),
        .q_o (req_sync)
    );

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic             ack_q;
    logic             ack_d;
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             pending;

    // A transfer is outstanding whenever the sender's toggle and ours differ.
    assign pending = req_sync ^ ack_q;

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------------
    // data_a is sampled only on the IDLE->VALID step. By then req_a has taken
    // SYNC_STAGES clk_b edges to arrive, so the sender's data has long since
    // settled and needs no synchronizer of its own.
    always_comb begin
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    data_d  = bus.data_a;
                    valid_d = 1'b1;
                end
            end
            VALID: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.ack_b     = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;

    // ------------------------------------------------------------------------
    // Overrun detection
    // ------------------------------------------------------------------------
`ifdef DOMAIN_CROSS_OVERRUN_DET_EN
    logic overrun_q;
    logic overrun_d;

    // While a word is held, req_sync must still differ from ack_b. If they
    // match, the sender toggled again before our acknowledge: flag it and
    // keep the flag until reset. The held word and FSM are left alone.
    always_comb begin
        overrun_d = overrun_q;
        if ((state_q == VALID) && !pending) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule : handshake_domain_rx
`default_nettype wire

// File: tb/tb_handshake_domain_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_handshake_domain_rx
//  Description : Self-checking bench for handshake_domain_rx. Expected words
//                are queued when the sender drives them and compared when the
//                receiver completes a valid/ready handshake.
//  Options     : DOMAIN_CROSS_OVERRUN_DET_EN selects the expected overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_domain_rx;

    localparam int WIDTH     = 32;
    localparam int N_STREAM  = 256;
`ifdef DOMAIN_CROSS_OVERRUN_DET_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic clk_b = 1'b0;
    logic clk_a = 1'b0;
    logic rst;

    always #7 clk_b = ~clk_b;
    always #3 clk_a = ~clk_a;

    handshake_domain_rx_if #(.WIDTH(WIDTH)) bus ();

    handshake_domain_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk_b (clk_b),
        .rst   (rst),
        .bus   (bus)
    );

    // Sender-side synchronizer for ack_b, as the real transmitter would use.
    logic ack_s1;
    logic ack_s2;
    always @(posedge clk_a or posedge rst) begin
        if (rst) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= bus.ack_b;
            ack_s2 <= ack_s1;
        end
    end

    int               n_checks;
    int               n_errors;
    int               n_rx;
    logic [WIDTH-1:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic send_stream();
        int guard;
        for (int i = 1; i <= N_STREAM; i++) begin
            guard = 0;
            while ((ack_s2 !== bus.req_a) && (guard < 2000)) begin
                @(posedge clk_a);
                guard++;
            end
            if (guard >= 2000) begin
                check("sender_ack_timeout", 64'(guard), 64'(0));
                return;
            end
            @(posedge clk_a);
            #1;
            bus.data_a = WIDTH'(i);
            sb.push_back(WIDTH'(i));
            @(posedge clk_a);
            #1;
            bus.req_a = ~bus.req_a;
        end
    endtask

    task automatic consume();
        int cyc;
        cyc = 0;
        while ((n_rx < N_STREAM) && (cyc < 20000)) begin
            tick();
            bus.out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        check("stream_count", 64'(n_rx), 64'(N_STREAM));
    endtask

    initial begin : main
        n_checks      = 0;
        n_errors      = 0;
        n_rx          = 0;
        rst           = 1'b1;
        bus.req_a     = 1'b1;
        bus.data_a    = 32'h1234_5678;
        bus.out_ready = 1'b1;

        // Scoreboard monitor: a word is consumed at the edge following a
        // cycle with out_valid && out_ready.
        fork
            begin : monitor
                logic [WIDTH-1:0] e;
                forever begin
                    @(negedge clk_b);
                    if (!rst && bus.out_valid && bus.out_ready) begin
                        if (sb.size() == 0) begin
                            check("unexpected_word", 64'(bus.out_valid), 64'(0));
                        end else begin
                            e = sb.pop_front();
                            check("word_data", 64'(bus.out_data), 64'(e));
                            n_rx++;
                        end
                    end
                end
            end
        join_none

        // ---------------- reset with req_a high ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ack", 64'(bus.ack_b), 64'(0));
            check("rst_valid", 64'(bus.out_valid), 64'(0));
            check("rst_data", 64'(bus.out_data), 64'(0));
            check("rst_overrun", 64'(bus.overrun), 64'(0));
        end
        bus.req_a = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", 64'(bus.out_valid), 64'(0));

        // ---------------- single transfer ----------------
        bus.data_a = 32'hDEAD_BEEF;
        sb.push_back(32'hDEAD_BEEF);
        bus.req_a = 1'b1;
        tick();
        check("lat_edge1_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("lat_edge2_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("single_valid", 64'(bus.out_valid), 64'(1));
        check("single_data", 64'(bus.out_data), 64'(32'hDEAD_BEEF));
        check("single_ack_before", 64'(bus.ack_b), 64'(0));
        tick();
        check("single_ack_after", 64'(bus.ack_b), 64'(1));
        check("single_valid_1cyc", 64'(bus.out_valid), 64'(0));

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        bus.data_a = 32'hDEAD_BEEF;
        sb.push_back(32'hDEAD_BEEF);
        bus.req_a = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'(1));
            check("bp_data", 64'(bus.out_data), 64'(32'hDEAD_BEEF));
            check("bp_ack_held", 64'(bus.ack_b), 64'(1));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_ack_toggle", 64'(bus.ack_b), 64'(0));
        check("bp_valid_drop", 64'(bus.out_valid), 64'(0));
        bus.out_ready = 1'b0;
        repeat (4) tick();
        check("no_double_capture", 64'(bus.out_valid), 64'(0));

        // ---------------- overrun (sender toggles twice while held) -------
        bus.data_a = 32'hA5A5_0001;
        sb.push_back(32'hA5A5_0001);
        bus.req_a = 1'b1;
        repeat (3) tick();
        check("ovr_valid", 64'(bus.out_valid), 64'(1));
        check("ovr_clear_before", 64'(bus.overrun), 64'(0));
        bus.data_a = 32'h0BAD_0BAD;
        bus.req_a = 1'b0;
        repeat (3) tick();
        check("ovr_flag", 64'(bus.overrun), 64'(OVR_EXP));
        check("ovr_data_kept", 64'(bus.out_data), 64'(32'hA5A5_0001));
        bus.req_a = 1'b1;
        repeat (4) tick();
        check("ovr_sticky", 64'(bus.overrun), 64'(OVR_EXP));
        check("ovr_valid_kept", 64'(bus.out_valid), 64'(1));
        check("ovr_ack_kept", 64'(bus.ack_b), 64'(0));

        // ---------------- reset mid-VALID ----------------
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_ack", 64'(bus.ack_b), 64'(0));
        check("midrst_data", 64'(bus.out_data), 64'(0));
        check("midrst_overrun", 64'(bus.overrun), 64'(0));
        bus.req_a = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_no_spurious", 64'(bus.out_valid), 64'(0));
        end

        // ---------------- stream on unrelated clock ----------------
        bus.out_ready = 1'b0;
        n_rx = 0;
        fork
            send_stream();
            consume();
        join
        bus.out_ready = 1'b0;
        repeat (6) tick();
        check("stream_final_ack", 64'(bus.ack_b), 64'(0));
        check("stream_sb_empty", 64'(sb.size()), 64'(0));
        check("stream_final_valid", 64'(bus.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_handshake_domain_rx
`default_nettype wire
